// File: rtl/lfsr_gen_if.sv
// Stream/control bundle for lfsr_gen: seed load, run enable and the Q valid/ready output.
interface lfsr_gen_if #(
    parameter int N = 32
);
    logic         init;
    logic [N-1:0] seed;
    logic         go;
    logic         q_ready;
    logic [N-1:0] q;
    logic         q_valid;
    logic         zero_seed;

    modport master (
        input  init, seed, go, q_ready,
        output q, q_valid, zero_seed
    );

    modport slave (
        output init, seed, go, q_ready,
        input  q, q_valid, zero_seed
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with valid/ready output and zero-seed guard.
// Define LFSR_PERIOD_CNT_EN to add the count_o/wrap_o period-tracking ports.
module lfsr_gen #(
    parameter int          N       = 32,
    parameter logic [63:0] TAPS    = 64'h0040_0007,
    parameter int          STEP    = 1,
    parameter logic [63:0] RST_VAL = 64'h1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lfsr_gen_if.master    bus
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [N-1:0]  count_o,
    output logic          wrap_o
`endif
);
    localparam logic [N-1:0] TAPS_N = TAPS[N-1:0];
    localparam logic [N-1:0] RST_N  = RST_VAL[N-1:0];

    typedef enum logic {IDLE, RUN} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic         zero_q, zero_d;
    logic [N-1:0] adv;
    logic         fire;
    logic [N-1:0] load_val;

    // STEP single shifts, unrolled into one combinational advance.
    function automatic logic [N-1:0] lfsr_advance(input logic [N-1:0] s);
        logic [N-1:0] v;
        v = s;
        for (int i = 0; i < STEP; i++) begin
            v = {^(v & TAPS_N), v[N-1:1]};
        end
        return v;
    endfunction

    assign adv      = lfsr_advance(q_q);
    assign fire     = (state_q == RUN) && bus.q_ready;
    assign load_val = (bus.seed == '0) ? RST_N : bus.seed;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        zero_d  = 1'b0;
        if (bus.init) begin
            state_d = IDLE;
            q_d     = load_val;
            zero_d  = (bus.seed == '0);
        end else begin
            case (state_q)
                IDLE:    if (bus.go)  state_d = RUN;
                RUN:     if (!bus.go) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (fire) q_d = adv;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            q_q     <= RST_N;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.q_valid   = (state_q == RUN);
    assign bus.zero_seed = zero_q;

`ifdef LFSR_PERIOD_CNT_EN
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] last_q, last_d;
    logic         wrap_q, wrap_d;

    // Period boundary: the advanced state returns to whatever was last loaded.
    always_comb begin
        count_d = count_q;
        last_d  = last_q;
        wrap_d  = 1'b0;
        if (bus.init) begin
            count_d = '0;
            last_d  = load_val;
        end else if (fire) begin
            if (adv == last_q) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            last_q  <= RST_N;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
`endif
endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: reset, seeding, zero-seed guard, backpressure, generation, period.
module tb_lfsr_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lfsr_gen_if #(.N(32)) b32 ();
    lfsr_gen_if #(.N(8))  b8 ();
    lfsr_gen_if #(.N(8))  b8s ();

`ifdef LFSR_PERIOD_CNT_EN
    logic [31:0] c32;
    logic [7:0]  c8, c8s;
    logic        w32, w8, w8s;
`endif

    lfsr_gen #(.N(32)) u32 (
        .clk_i(clk), .rst_i(rst), .bus(b32)
`ifdef LFSR_PERIOD_CNT_EN
        , .count_o(c32), .wrap_o(w32)
`endif
    );

    lfsr_gen #(.N(8), .TAPS(64'h1D), .STEP(1)) u8 (
        .clk_i(clk), .rst_i(rst), .bus(b8)
`ifdef LFSR_PERIOD_CNT_EN
        , .count_o(c8), .wrap_o(w8)
`endif
    );

    lfsr_gen #(.N(8), .TAPS(64'h1D), .STEP(4)) u8s (
        .clk_i(clk), .rst_i(rst), .bus(b8s)
`ifdef LFSR_PERIOD_CNT_EN
        , .count_o(c8s), .wrap_o(w8s)
`endif
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b32.init = 0; b32.seed = '0; b32.go = 0; b32.q_ready = 0;
        b8.init  = 0; b8.seed  = '0; b8.go  = 0; b8.q_ready  = 0;
        b8s.init = 0; b8s.seed = '0; b8s.go = 0; b8s.q_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        checks++; if (b32.q !== 32'h1) begin failures++; $display("FAIL reset_q got=%h exp=%h", b32.q, 32'h1); end
        checks++; if (b32.q_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", b32.q_valid); end
        checks++; if (b32.zero_seed !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", b32.zero_seed); end
        checks++; if (b8.q !== 8'h01) begin failures++; $display("FAIL reset_q8 got=%h exp=01", b8.q); end
`ifdef LFSR_PERIOD_CNT_EN
        checks++; if (c8 !== 8'h0 || w8 !== 1'b0) begin failures++; $display("FAIL reset_cnt got=%h/%b exp=00/0", c8, w8); end
`endif
    endtask

    task automatic test_init();
        b32.init = 1; b32.seed = 32'h12345678;
        tick();
        b32.init = 0;
        checks++; if (b32.q !== 32'h12345678) begin failures++; $display("FAIL init_q got=%h exp=12345678", b32.q); end
        checks++; if (b32.q_valid !== 1'b0) begin failures++; $display("FAIL init_valid got=%b exp=0", b32.q_valid); end
        checks++; if (b32.zero_seed !== 1'b0) begin failures++; $display("FAIL init_nozero got=%b exp=0", b32.zero_seed); end
    endtask

    task automatic test_zero_seed();
        int zero_hits = 0;
        b32.init = 1; b32.seed = 32'h0;
        tick();
        b32.init = 0;
        checks++; if (b32.q !== 32'h1) begin failures++; $display("FAIL zseed_q got=%h exp=1", b32.q); end
        checks++; if (b32.zero_seed !== 1'b1) begin failures++; $display("FAIL zseed_pulse got=%b exp=1", b32.zero_seed); end
        b32.go = 1; b32.q_ready = 1;
        tick();
        checks++; if (b32.zero_seed !== 1'b0) begin failures++; $display("FAIL zseed_oneshot got=%b exp=0", b32.zero_seed); end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (b32.q == 32'h0) zero_hits++;
        end
        checks++; if (zero_hits != 0) begin failures++; $display("FAIL zseed_never_zero got=%0d exp=0", zero_hits); end
        checks++; if (b32.q_valid !== 1'b1) begin failures++; $display("FAIL zseed_run_valid got=%b exp=1", b32.q_valid); end
        b32.go = 0; b32.q_ready = 0;
        tick();
    endtask

    task automatic test_storage();
        int moved = 0;
        int invalid = 0;
        b32.init = 1; b32.seed = 32'h9ABCDEF0;
        tick();
        b32.init = 0; b32.go = 1; b32.q_ready = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b32.q !== 32'h9ABCDEF0) moved++;
            if (b32.q_valid !== 1'b1) invalid++;
        end
        checks++; if (moved != 0) begin failures++; $display("FAIL stall_hold got=%0d exp=0", moved); end
        checks++; if (invalid != 0) begin failures++; $display("FAIL stall_valid got=%0d exp=0", invalid); end
        b32.go = 0;
        tick();
        checks++; if (b32.q_valid !== 1'b0) begin failures++; $display("FAIL stop_valid got=%b exp=0", b32.q_valid); end
        checks++; if (b32.q !== 32'h9ABCDEF0) begin failures++; $display("FAIL stop_hold got=%h exp=9abcdef0", b32.q); end
    endtask

    task automatic test_generation();
        logic [7:0] exp_seq [5] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        b8.init = 1;  b8.seed = 8'h01;
        b8s.init = 1; b8s.seed = 8'h01;
        tick();
        b8.init = 0;  b8.go = 1;  b8.q_ready = 1;
        b8s.init = 0; b8s.go = 1; b8s.q_ready = 1;
        tick();
        checks++; if (b8.q_valid !== 1'b1 || b8.q !== 8'h01) begin failures++; $display("FAIL gen_first_valid got=%b/%h exp=1/01", b8.q_valid, b8.q); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                checks++; if (b8s.q !== 8'h10) begin failures++; $display("FAIL gen_step4 got=%h exp=10", b8s.q); end
            end
            checks++; if (b8.q !== exp_seq[i]) begin failures++; $display("FAIL gen_seq%0d got=%h exp=%h", i, b8.q, exp_seq[i]); end
        end
        b8s.go = 0; b8s.q_ready = 0;
        b8.q_ready = 0;
        tick();
        tick();
        checks++; if (b8.q !== 8'h88 || b8.q_valid !== 1'b1) begin failures++; $display("FAIL gen_backpressure got=%h/%b exp=88/1", b8.q, b8.q_valid); end
        b8.q_ready = 1;
    endtask

    task automatic test_init_over_handshake();
        b8.init = 1; b8.seed = 8'h55;
        tick();
        b8.init = 0;
        checks++; if (b8.q !== 8'h55) begin failures++; $display("FAIL init_win_q got=%h exp=55", b8.q); end
        checks++; if (b8.q_valid !== 1'b0) begin failures++; $display("FAIL init_win_valid got=%b exp=0", b8.q_valid); end
        tick();
        checks++; if (b8.q !== 8'h55 || b8.q_valid !== 1'b1) begin failures++; $display("FAIL init_rerun got=%h/%b exp=55/1", b8.q, b8.q_valid); end
        // Handshake on the edge that sees GO low still advances.
        b8.go = 0;
        tick();
        checks++; if (b8.q !== 8'hAA || b8.q_valid !== 1'b0) begin failures++; $display("FAIL go_drop_adv got=%h/%b exp=aa/0", b8.q, b8.q_valid); end
        b8.q_ready = 0;
    endtask

    task automatic test_period();
        int early = 0;
        b8.init = 1; b8.seed = 8'h01;
        tick();
        b8.init = 0; b8.go = 1; b8.q_ready = 1;
        tick();
        for (int i = 1; i <= 254; i++) begin
            tick();
            if (b8.q == 8'h01) early++;
`ifdef LFSR_PERIOD_CNT_EN
            if (w8 !== 1'b0) early++;
`endif
        end
`ifdef LFSR_PERIOD_CNT_EN
        checks++; if (c8 !== 8'd254) begin failures++; $display("FAIL period_cnt254 got=%0d exp=254", c8); end
`endif
        checks++; if (early != 0) begin failures++; $display("FAIL period_early got=%0d exp=0", early); end
        tick();
        checks++; if (b8.q !== 8'h01) begin failures++; $display("FAIL period_wrap_q got=%h exp=01", b8.q); end
`ifdef LFSR_PERIOD_CNT_EN
        checks++; if (w8 !== 1'b1 || c8 !== 8'h0) begin failures++; $display("FAIL period_wrap got=%b/%h exp=1/00", w8, c8); end
        tick();
        checks++; if (w8 !== 1'b0 || c8 !== 8'h1) begin failures++; $display("FAIL period_after got=%b/%h exp=0/01", w8, c8); end
`endif
    endtask

    task automatic test_rst_mid();
        b8.go = 1; b8.q_ready = 1; b8.init = 1; b8.seed = 8'h77;
        rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        checks++; if (b8.q !== 8'h01 || b8.q_valid !== 1'b0) begin failures++; $display("FAIL rst_mid got=%h/%b exp=01/0", b8.q, b8.q_valid); end
        checks++; if (b8.zero_seed !== 1'b0) begin failures++; $display("FAIL rst_mid_zero got=%b exp=0", b8.zero_seed); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_zero_seed();
        test_storage();
        test_generation();
        test_init_over_handshake();
        test_period();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
